// File: rtl/vmac_pkg.sv
// Shared types for the VMAC issue controller: FSM states, queued command
// record and common widths.
package vmac_pkg;

  localparam int VREG_AW  = 5;
  localparam int RETIRE_W = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    LATCH = 3'd2,
    START = 3'd3,
    WAIT  = 3'd4,
    WB    = 3'd5
  } vmac_state_e;

  typedef struct packed {
    logic [VREG_AW-1:0] vd;
    logic [VREG_AW-1:0] vs1;
    logic [VREG_AW-1:0] vs2;
    logic [VREG_AW-1:0] vs3;
  } vmac_cmd_t;

endpackage

// File: rtl/vmac_cmd_fifo.sv
// Show-ahead command queue; ready_o is registered and only high when a slot
// is free, so a push is refused when full even if a pop happens that cycle.
module vmac_cmd_fifo
  import vmac_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      push_i,
  input  vmac_cmd_t data_i,
  output logic      ready_o,
  input  logic      pop_i,
  output logic      empty_o,
  output vmac_cmd_t head_o
);

  localparam int PW = $clog2(DEPTH);

  vmac_cmd_t     mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [PW:0]   cnt_q, cnt_d;
  logic          ready_q;
  logic          push_s, pop_s;

  assign push_s = push_i && ready_q;
  assign pop_s  = pop_i && (cnt_q != '0);

  always_comb begin
    cnt_d = cnt_q;
    if (push_s && !pop_s) begin
      cnt_d = cnt_q + 1'b1;
    end else if (pop_s && !push_s) begin
      cnt_d = cnt_q - 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      if (push_s) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop_s) begin
        rd_q <= rd_q + 1'b1;
      end
      cnt_q   <= cnt_d;
      ready_q <= (cnt_d != (PW+1)'(DEPTH));
    end
  end

  assign ready_o = ready_q;
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_q];

endmodule

// File: rtl/vmac_issue_ctrl.sv
// VMAC issue controller: queues vd = vs1*vs2 + vs3, reads operands, runs the
// start/done handshake and writes back. Define VMAC_ISSUE_CHECK_EN for the result checker.
module vmac_issue_ctrl
  import vmac_pkg::*;
#(
  parameter int VLEN           = 256,
  parameter int ELEMENT_WIDTH  = 32,
  parameter int NUM_VREGS      = 32,
  parameter int CMD_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 16,
  localparam int AW            = $clog2(NUM_VREGS)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [AW-1:0]       cmd_vd_i,
  input  logic [AW-1:0]       cmd_vs1_i,
  input  logic [AW-1:0]       cmd_vs2_i,
  input  logic [AW-1:0]       cmd_vs3_i,
  output logic [AW-1:0]       rf_raddr_a_o,
  output logic [AW-1:0]       rf_raddr_b_o,
  output logic [AW-1:0]       rf_raddr_c_o,
  input  logic [VLEN-1:0]     rf_rdata_a_i,
  input  logic [VLEN-1:0]     rf_rdata_b_i,
  input  logic [VLEN-1:0]     rf_rdata_c_i,
  output logic                mac_start_o,
  input  logic                mac_done_i,
  output logic [VLEN-1:0]     mac_vec_a_o,
  output logic [VLEN-1:0]     mac_vec_b_o,
  output logic [VLEN-1:0]     mac_vec_c_o,
  input  logic [VLEN-1:0]     mac_result_i,
  output logic                wb_valid_o,
  output logic [AW-1:0]       wb_addr_o,
  output logic [VLEN-1:0]     wb_data_o,
  input  logic                wb_ready_i,
  output logic                busy_o,
  output logic                err_timeout_o,
  output logic                err_mismatch_o,
  output logic [RETIRE_W-1:0] retired_cnt_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  if ((VLEN % ELEMENT_WIDTH) != 0 || CMD_DEPTH < 2) begin : g_cfg_check
    $error("vmac_issue_ctrl: VLEN must be a multiple of ELEMENT_WIDTH and CMD_DEPTH >= 2");
  end

  vmac_state_e         state_q;
  vmac_cmd_t           cmd_q, fifo_head_s, fifo_in_s;
  logic                fifo_empty_s, pop_s, capture_s;
  logic [AW-1:0]       raddr_a_q, raddr_b_q, raddr_c_q;
  logic [VLEN-1:0]     vec_a_q, vec_b_q, vec_c_q, wb_data_q;
  logic                mac_start_q, wb_valid_q, err_timeout_q;
  logic [TW-1:0]       timer_q;
  logic [RETIRE_W-1:0] retired_q;

  assign fifo_in_s = '{vd: cmd_vd_i, vs1: cmd_vs1_i, vs2: cmd_vs2_i, vs3: cmd_vs3_i};
  assign pop_s     = (state_q == IDLE) && !fifo_empty_s;
  assign capture_s = mac_done_i && ((state_q == START) || (state_q == WAIT));

  vmac_cmd_fifo #(.DEPTH(CMD_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (cmd_valid_i),
    .data_i  (fifo_in_s),
    .ready_o (cmd_ready_o),
    .pop_i   (pop_s),
    .empty_o (fifo_empty_s),
    .head_o  (fifo_head_s)
  );

  // Operands stay frozen from LATCH until the next command is latched.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      cmd_q         <= '0;
      raddr_a_q     <= '0;
      raddr_b_q     <= '0;
      raddr_c_q     <= '0;
      vec_a_q       <= '0;
      vec_b_q       <= '0;
      vec_c_q       <= '0;
      wb_data_q     <= '0;
      mac_start_q   <= 1'b0;
      wb_valid_q    <= 1'b0;
      err_timeout_q <= 1'b0;
      timer_q       <= '0;
      retired_q     <= '0;
    end else begin
      mac_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!fifo_empty_s) begin
            cmd_q     <= fifo_head_s;
            raddr_a_q <= fifo_head_s.vs1;
            raddr_b_q <= fifo_head_s.vs2;
            raddr_c_q <= fifo_head_s.vs3;
            state_q   <= READ;
          end
        end
        READ: state_q <= LATCH;
        LATCH: begin
          vec_a_q     <= rf_rdata_a_i;
          vec_b_q     <= rf_rdata_b_i;
          vec_c_q     <= rf_rdata_c_i;
          mac_start_q <= 1'b1;
          state_q     <= START;
        end
        START: begin
          if (mac_done_i) begin
            wb_data_q  <= mac_result_i;
            wb_valid_q <= 1'b1;
            state_q    <= WB;
          end else begin
            timer_q <= '0;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (mac_done_i) begin
            wb_data_q  <= mac_result_i;
            wb_valid_q <= 1'b1;
            state_q    <= WB;
          end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
            err_timeout_q <= 1'b1;
            state_q       <= IDLE;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        WB: begin
          if (wb_ready_i) begin
            wb_valid_q <= 1'b0;
            retired_q  <= retired_q + 1'b1;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef VMAC_ISSUE_CHECK_EN
  localparam int NL = VLEN / ELEMENT_WIDTH;

  function automatic logic [NL-1:0] lane_mismatch(input logic [VLEN-1:0] a, input logic [VLEN-1:0] b,
                                                   input logic [VLEN-1:0] c, input logic [VLEN-1:0] r);
    logic [ELEMENT_WIDTH-1:0] e;
    lane_mismatch = '0;
    for (int l = 0; l < NL; l++) begin
      e = a[l*ELEMENT_WIDTH +: ELEMENT_WIDTH] * b[l*ELEMENT_WIDTH +: ELEMENT_WIDTH]
        + c[l*ELEMENT_WIDTH +: ELEMENT_WIDTH];
      lane_mismatch[l] = (e != r[l*ELEMENT_WIDTH +: ELEMENT_WIDTH]);
    end
  endfunction

  logic [NL-1:0] mis_s;
  logic          err_mismatch_q;

  assign mis_s = lane_mismatch(vec_a_q, vec_b_q, vec_c_q, mac_result_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_mismatch_q <= 1'b0;
    end else if (capture_s && (|mis_s)) begin
      err_mismatch_q <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!rst_i && capture_s) begin
      for (int l = 0; l < NL; l++) begin
        if (mis_s[l]) $error("vmac_issue_ctrl: result mismatch in lane %0d", l);
      end
    end
  end
`endif

  assign err_mismatch_o = err_mismatch_q;
`else
  assign err_mismatch_o = 1'b0;
`endif

  assign rf_raddr_a_o  = raddr_a_q;
  assign rf_raddr_b_o  = raddr_b_q;
  assign rf_raddr_c_o  = raddr_c_q;
  assign mac_start_o   = mac_start_q;
  assign mac_vec_a_o   = vec_a_q;
  assign mac_vec_b_o   = vec_b_q;
  assign mac_vec_c_o   = vec_c_q;
  assign wb_valid_o    = wb_valid_q;
  assign wb_addr_o     = cmd_q.vd;
  assign wb_data_o     = wb_data_q;
  assign busy_o        = (state_q != IDLE) || !fifo_empty_s;
  assign err_timeout_o = err_timeout_q;
  assign retired_cnt_o = retired_q;

endmodule

// File: tb/tb_vmac_issue_ctrl.sv
// Scoreboard bench for vmac_issue_ctrl: directed commands push expected
// writebacks; a negedge monitor pops and compares every accepted writeback.
module tb_vmac_issue_ctrl;

  localparam int VLEN = 256;
  localparam int EW   = 32;
  localparam int NL   = VLEN / EW;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            cmd_valid = 1'b0, cmd_ready;
  logic [AW-1:0]   cmd_vd = '0, cmd_vs1 = '0, cmd_vs2 = '0, cmd_vs3 = '0;
  logic [AW-1:0]   raddr_a, raddr_b, raddr_c;
  logic [VLEN-1:0] rd_a = '0, rd_b = '0, rd_c = '0;
  logic            mac_start, mac_done;
  logic [VLEN-1:0] vec_a, vec_b, vec_c, mac_res;
  logic            wb_valid, wb_ready = 1'b1;
  logic [AW-1:0]   wb_addr;
  logic [VLEN-1:0] wb_data;
  logic            busy, err_timeout, err_mismatch;
  logic [15:0]     retired;

  logic [VLEN-1:0] rf [32];
  int              delay = 0;
  int              dcnt = 0;
  logic            force_done = 1'b0;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  typedef struct {
    logic [AW-1:0]   addr;
    logic [VLEN-1:0] data;
  } exp_t;
  exp_t sb[$];

  vmac_issue_ctrl dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_vd_i(cmd_vd), .cmd_vs1_i(cmd_vs1), .cmd_vs2_i(cmd_vs2), .cmd_vs3_i(cmd_vs3),
    .rf_raddr_a_o(raddr_a), .rf_raddr_b_o(raddr_b), .rf_raddr_c_o(raddr_c),
    .rf_rdata_a_i(rd_a), .rf_rdata_b_i(rd_b), .rf_rdata_c_i(rd_c),
    .mac_start_o(mac_start), .mac_done_i(mac_done),
    .mac_vec_a_o(vec_a), .mac_vec_b_o(vec_b), .mac_vec_c_o(vec_c),
    .mac_result_i(mac_res),
    .wb_valid_o(wb_valid), .wb_addr_o(wb_addr), .wb_data_o(wb_data), .wb_ready_i(wb_ready),
    .busy_o(busy), .err_timeout_o(err_timeout), .err_mismatch_o(err_mismatch),
    .retired_cnt_o(retired)
  );

  always #5 clk = ~clk;

  // Register file with one-cycle read latency.
  always @(posedge clk) begin
    rd_a <= rf[raddr_a];
    rd_b <= rf[raddr_b];
    rd_c <= rf[raddr_c];
  end

  // MAC unit: immediate (delay 0), delayed (delay > 0) or silent (delay < 0).
  always @(posedge clk) begin
    if (rst) dcnt <= 0;
    else if (mac_start && delay > 0) dcnt <= delay;
    else if (dcnt > 0) dcnt <= dcnt - 1;
  end
  assign mac_done = force_done | ((delay == 0) ? mac_start : (dcnt == 1));

  always_comb begin
    mac_res = '0;
    for (int l = 0; l < NL; l++)
      mac_res[l*EW +: EW] = vec_a[l*EW +: EW] * vec_b[l*EW +: EW] + vec_c[l*EW +: EW];
  end

  function automatic logic [VLEN-1:0] fill(input logic [EW-1:0] v);
    logic [VLEN-1:0] r;
    for (int l = 0; l < NL; l++) r[l*EW +: EW] = v;
    return r;
  endfunction

  task automatic check(input string name, input logic [VLEN-1:0] act, input logic [VLEN-1:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Scoreboard monitor: compares each writeback at the cycle it is accepted.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && wb_valid && wb_ready) begin
      if (sb.size() == 0) begin
        chk_cnt++;
        $display("FAIL wb_unexpected: got writeback to vd %0d, expected none", wb_addr);
      end else begin
        e = sb.pop_front();
        check("wb_addr", VLEN'(wb_addr), VLEN'(e.addr));
        check("wb_data", wb_data, e.data);
      end
    end
  end

  task automatic push(input logic [AW-1:0] vd, input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                      input logic [AW-1:0] s3, input bit exp_en, input logic [VLEN-1:0] exp_d);
    int n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      chk_cnt++;
      $display("FAIL push_ready: got cmd_ready_o 0 for %0d cycles, expected 1", n);
    end
    cmd_valid = 1'b1;
    cmd_vd = vd; cmd_vs1 = s1; cmd_vs2 = s2; cmd_vs3 = s3;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    if (exp_en) sb.push_back('{vd, exp_d});
  endtask

  task automatic drain(input int max);
    int n = 0;
    while ((sb.size() != 0 || busy) && n < max) begin
      @(negedge clk);
      n++;
    end
    check("drain_sb", VLEN'(sb.size()), '0);
    check("drain_busy", VLEN'(busy), '0);
  endtask

  task automatic wait_wb(input int max);
    int n = 0;
    while (!wb_valid && n < max) begin
      @(posedge clk);
      #1 n++;
    end
    check("wb_arrives", VLEN'(wb_valid), VLEN'(1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got time limit, expected completion");
    $fatal(1);
  end

  initial begin
    logic [VLEN-1:0] e8, a0, b0, c0, d0;
    logic [AW-1:0]   ad0;
    logic [15:0]     r0;
    int n, starts, acc, t0, t1, rises;
    bit ok, rdy, prev;
    logic [AW-1:0] ov [6][3];
    logic [EW-1:0] oe [6];

    for (int i = 0; i < 32; i++) rf[i] = '0;
    rf[1] = fill(32'd3);
    rf[2] = fill(32'd4);
    rf[3] = fill(32'd5);
    for (int l = 0; l < NL; l++) rf[8][l*EW +: EW] = 32'(l + 1);
    rf[9] = fill(32'hFFFF_FFFF);
    for (int l = 0; l < NL; l++) e8[l*EW +: EW] = 32'((l + 1) * 4 + 5);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", VLEN'(cmd_ready), '0);
    check("rst_busy", VLEN'(busy), '0);
    check("rst_outs", VLEN'({wb_valid, mac_start, err_timeout, err_mismatch}), '0);
    check("rst_retired", VLEN'(retired), '0);
    check("rst_vec_a", vec_a, '0);
    check("rst_wb_data", wb_data, '0);
    rst = 1'b0;
    @(negedge clk);

    // Immediate done: 3*4+5 in every lane, 4-edge latency
    push(5'd7, 5'd1, 5'd2, 5'd3, 1'b1, fill(32'd17));
    n = 0;
    while (!wb_valid && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    check("latency_edges", VLEN'(n), VLEN'(4));
    drain(20);
    check("retired_1", VLEN'(retired), VLEN'(1));

    // Lane-distinct operands, wraparound lanes, back-to-back throughput
    push(5'd10, 5'd8, 5'd2, 5'd3, 1'b1, e8);
    push(5'd11, 5'd9, 5'd9, 5'd1, 1'b1, fill(32'd4));
    rises = 0; prev = wb_valid; t0 = 0; t1 = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (wb_valid && !prev) begin
        if (rises == 0) t0 = c;
        else t1 = c;
        rises++;
      end
      prev = wb_valid;
    end
    check("throughput", VLEN'(t1 - t0), VLEN'(5));
    drain(20);
    check("retired_3", VLEN'(retired), VLEN'(3));

    // Stray done while idle is ignored
    @(posedge clk);
    #1 force_done = 1'b1;
    repeat (3) @(posedge clk);
    #1 force_done = 1'b0;
    @(negedge clk);
    check("stray_done", VLEN'({busy, wb_valid, mac_start}), '0);
    check("stray_retired", VLEN'(retired), VLEN'(3));

    // Done 3 cycles after start: single start pulse, operands held
    delay = 3;
    push(5'd12, 5'd3, 5'd3, 5'd1, 1'b1, fill(32'd28));
    starts = 0; ok = 1'b1; n = 0;
    while (!wb_valid && n < 40) begin
      @(negedge clk);
      n++;
      if (mac_start) begin
        starts++;
        a0 = vec_a; b0 = vec_b; c0 = vec_c;
      end else if (starts > 0 && !wb_valid && (vec_a !== a0 || vec_b !== b0 || vec_c !== c0)) begin
        ok = 1'b0;
      end
    end
    check("start_pulses", VLEN'(starts), VLEN'(1));
    check("ops_stable", VLEN'(ok), VLEN'(1));
    check("op_a", vec_a, fill(32'd5));
    check("op_c", vec_c, fill(32'd3));
    drain(20);
    check("no_timeout", VLEN'(err_timeout), '0);
    delay = 0;

    // Writeback back-pressure for 5 cycles
    @(posedge clk);
    #1 wb_ready = 1'b0;
    push(5'd13, 5'd1, 5'd1, 5'd2, 1'b1, fill(32'd13));
    wait_wb(20);
    d0 = wb_data; ad0 = wb_addr; r0 = retired; ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (!wb_valid || wb_data !== d0 || wb_addr !== ad0 || retired !== r0) ok = 1'b0;
    end
    check("wb_hold", VLEN'(ok), VLEN'(1));
    @(posedge clk);
    #1 wb_ready = 1'b1;
    @(posedge clk);
    #1;
    check("retire_on_accept", VLEN'(retired), VLEN'(5));
    check("wb_drop", VLEN'(wb_valid), '0);
    drain(20);

    // Queue fills to 4 while stalled in WB; order preserved
    ov[0] = '{5'd1, 5'd2, 5'd3}; oe[0] = 32'd17;
    ov[1] = '{5'd2, 5'd2, 5'd3}; oe[1] = 32'd21;
    ov[2] = '{5'd3, 5'd3, 5'd1}; oe[2] = 32'd28;
    ov[3] = '{5'd1, 5'd1, 5'd2}; oe[3] = 32'd13;
    ov[4] = '{5'd3, 5'd2, 5'd1}; oe[4] = 32'd23;
    ov[5] = '{5'd2, 5'd3, 5'd2}; oe[5] = 32'd24;
    @(posedge clk);
    #1 wb_ready = 1'b0;
    push(5'd14, 5'd1, 5'd2, 5'd3, 1'b1, fill(32'd17));
    wait_wb(20);
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      cmd_vd = 5'(15 + i); cmd_vs1 = ov[i][0]; cmd_vs2 = ov[i][1]; cmd_vs3 = ov[i][2];
      cmd_valid = 1'b1;
      rdy = cmd_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        sb.push_back('{5'(15 + i), fill(oe[i])});
        acc++;
      end
    end
    cmd_valid = 1'b0;
    check("accepted_4", VLEN'(acc), VLEN'(4));
    check("ready_full", VLEN'(cmd_ready), '0);
    wb_ready = 1'b1;
    drain(80);
    check("retired_10", VLEN'(retired), VLEN'(10));

    // Silent MAC: timeout after 16 WAIT cycles, next command proceeds
    delay = -1;
    push(5'd20, 5'd1, 5'd2, 5'd3, 1'b0, '0);
    push(5'd21, 5'd2, 5'd2, 5'd3, 1'b1, fill(32'd21));
    n = 0;
    while (!mac_start && n < 20) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (!err_timeout && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("timeout_cycles", VLEN'(n), VLEN'(17));
    delay = 0;
    drain(40);
    check("retired_11", VLEN'(retired), VLEN'(11));
    check("timeout_sticky", VLEN'(err_timeout), VLEN'(1));

    // Reset in WAIT with two commands queued
    delay = -1;
    push(5'd22, 5'd1, 5'd2, 5'd3, 1'b0, '0);
    push(5'd23, 5'd1, 5'd2, 5'd3, 1'b0, '0);
    push(5'd24, 5'd1, 5'd2, 5'd3, 1'b0, '0);
    n = 0;
    while (!mac_start && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_outs", VLEN'({busy, cmd_ready, mac_start, wb_valid, err_timeout}), '0);
    check("mid_rst_retired", VLEN'(retired), '0);
    check("mid_rst_vec_a", vec_a, '0);
    @(negedge clk);
    rst = 1'b0;
    delay = 0;
    repeat (30) @(negedge clk);
    check("post_rst_retired", VLEN'(retired), '0);
    check("post_rst_busy", VLEN'(busy), '0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/vmac_issue_ctrl.md
Name: vmac_issue_ctrl

Overview:
Initiator side of the VMAC start/done interface. Accepts vector MAC commands (vd = vs1*vs2 + vs3) into a small queue and fetches the three operands from the vector register file. It then drives the MAC unit's start/operand inputs, waits for done, and writes the result back to vd. It sits between the vector decode stage and the VMAC execution unit.

Parameters:
VLEN, 256, vector register width in bits
ELEMENT_WIDTH, 32, lane width in bits
NUM_VREGS, 32, number of architectural vector registers (address width = $clog2(NUM_VREGS))
CMD_DEPTH, 4, command queue depth (power of two, >= 2)
TIMEOUT_CYCLES, 16, max cycles in WAIT before abort

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  reset, asynchronous, active-high
cmd_valid_i  in  1  command offered
cmd_ready_o  out  1  queue not full
cmd_vd_i / cmd_vs1_i / cmd_vs2_i / cmd_vs3_i  in  AW each  destination and source register indices
rf_raddr_a_o / rf_raddr_b_o / rf_raddr_c_o  out  AW each  register file read addresses (1-cycle read latency)
rf_rdata_a_i / rf_rdata_b_i / rf_rdata_c_i  in  VLEN each  read data, valid the cycle after the address
mac_start_o  out  1  one-cycle start pulse to the MAC unit
mac_done_i  in  1  MAC done; may be high in the same cycle as start
mac_vec_a_o / mac_vec_b_o / mac_vec_c_o  out  VLEN each  operands, held stable from START until the result is captured
mac_result_i  in  VLEN  MAC result, valid when mac_done_i=1
wb_valid_o  out  1  writeback request
wb_addr_o  out  AW  writeback register index
wb_data_o  out  VLEN  writeback data
wb_ready_i  in  1  writeback accepted
busy_o  out  1  FSM not IDLE or queue non-empty
err_timeout_o  out  1  sticky timeout flag
err_mismatch_o  out  1  sticky result-check flag (see Optional Feature)
retired_cnt_o  out  16  completed commands, wraps at 2^16

Behaviour:
- Reset (async assert, sync release): FSM=IDLE, queue empty, all outputs 0, operand/result registers 0, cmd_ready_o=0 while rst_i=1.
- Queue: push on cmd_valid_i & cmd_ready_o. cmd_ready_o = !full; a push is refused when full even if a pop occurs the same cycle. Pointers wrap modulo CMD_DEPTH.
- FSM states:
  - IDLE: if the queue is non-empty, pop the head and go to READ.
  - READ: drive rf_raddr_* from the command; go to LATCH.
  - LATCH: register rf_rdata_* into operand registers; go to START.
  - START: mac_start_o=1 for exactly this cycle. If mac_done_i=1, capture mac_result_i and go to WB; otherwise go to WAIT and clear the timer.
  - WAIT: mac_start_o=0. On mac_done_i, capture the result and go to WB. Otherwise increment the timer; when it reaches TIMEOUT_CYCLES, set err_timeout_o, drop the command (no writeback, no retire) and go to IDLE.
  - WB: wb_valid_o=1 with wb_addr_o/wb_data_o stable until wb_ready_i. On the accepting edge, retired_cnt_o++ and go to IDLE.
- Latency: with an empty queue, an immediate done and wb_ready_i=1, wb_valid_o rises 4 edges after the push edge. Back-to-back throughput is 1 command per 5 cycles.
- mac_done_i outside START/WAIT is ignored.
- Arithmetic: none in the datapath; the counter wraps silently.
- err_* flags clear only on reset.
- Reset mid-operation: in-flight and queued commands are discarded; no writeback is issued.

Optional Feature:
VMAC_ISSUE_CHECK_EN
- Defined: on result capture, compute a*b+c per lane (mod 2^ELEMENT_WIDTH) from the held operands. Any lane differing from mac_result_i sets err_mismatch_o (sticky). Simulation builds also $error with the lane index.
- Undefined: no checker logic; err_mismatch_o tied 0.

Decomposition:
- Package vmac_pkg:
  - vmac_state_e enum (IDLE, READ, LATCH, START, WAIT, WB)
  - vmac_cmd_t struct {vd, vs1, vs2, vs3}
  - VREG_AW constant
  - retire counter width constant (16)
- Sub-module vmac_cmd_fifo: parameterised synchronous FIFO of vmac_cmd_t with full/empty flags and a show-ahead head.

Test Plan:
- All lanes a=3, b=4, c=5; immediate done; wb_ready_i=1 -> one wb to vd with every lane 17; wb_valid_o 4 edges after push; retired_cnt_o=1.
- MAC done delayed 3 cycles after start -> mac_start_o is a single-cycle pulse; operands stable through WAIT; correct wb; no error.
- wb_ready_i held low 5 cycles -> wb_valid_o/wb_addr_o/wb_data_o stable; retire only on the accepting edge.
- Push 6 commands back-to-back with the FSM stalled in WB -> cmd_ready_o drops after 4 accepted; all 4 later written back in order.
- mac_done_i never asserted -> err_timeout_o rises after 16 WAIT cycles; no wb; next queued command proceeds normally.
- rst_i pulsed in WAIT with 2 queued commands -> outputs 0 immediately; no writeback after release; retired_cnt_o=0.
